// File: rtl/dual_port_ram_pkg.sv
// Shared sizing defaults and word/address types for the 512x8 dual-port RAM.
package dual_port_ram_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/dual_port_ram_512x8.sv
// Simple dual-port synchronous RAM: port A read/write, port B read-only,
// shared clock and chip select, read-first on both ports, registered outputs.
module dual_port_ram_512x8 #(
  parameter int unsigned DATA_W = dual_port_ram_pkg::DATA_W,
  parameter int unsigned ADDR_W = dual_port_ram_pkg::ADDR_W,
  parameter int unsigned DEPTH  = dual_port_ram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_in_a,
  output logic [DATA_W-1:0] data_out_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_out_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_en_c;

  // A write in a reset cycle is dropped; contents themselves are never cleared.
  assign wr_en_c = cs & we_a & ~rst;

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[addr_a] <= data_in_a;
    end
  end

  // Output registers sample the pre-write word, giving read-first on both ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_a <= DATA_W'(0);
      data_out_b <= DATA_W'(0);
    end else if (cs) begin
      data_out_a <= mem[addr_a];
      data_out_b <= mem[addr_b];
    end
  end

endmodule

// File: tb/tb_dual_port_ram_512x8.sv
// Self-checking bench for dual_port_ram_512x8: vector table plus scoreboard queue.
module tb_dual_port_ram_512x8;
  import dual_port_ram_pkg::*;

  logic  clk;
  logic  rst;
  logic  cs;
  logic  we_a;
  addr_t addr_a;
  data_t data_in_a;
  data_t data_out_a;
  addr_t addr_b;
  data_t data_out_b;

  int checks;
  int errors;

  typedef struct {
    logic  cs;
    logic  we;
    addr_t aa;
    data_t din;
    addr_t ab;
    logic  ca;
    data_t ea;
    logic  cb;
    data_t eb;
  } vec_t;

  typedef struct {
    logic  ca;
    data_t ea;
    logic  cb;
    data_t eb;
    int    id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  dual_port_ram_512x8 dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .we_a       (we_a),
    .addr_a     (addr_a),
    .data_in_a  (data_in_a),
    .data_out_a (data_out_a),
    .addr_b     (addr_b),
    .data_out_b (data_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%02h, expected 0x%02h", name, id, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic w, input int aa, input int din, input int ab,
                     input logic ca, input int ea, input logic cb, input int eb);
    vec_t v;
    v.cs  = c;
    v.we  = w;
    v.aa  = addr_t'(aa);
    v.din = data_t'(din);
    v.ab  = addr_t'(ab);
    v.ca  = ca;
    v.ea  = data_t'(ea);
    v.cb  = cb;
    v.eb  = data_t'(eb);
    vecs.push_back(v);
  endtask

  // Drive one vector on the falling edge, queue its expectation, compare after the rising edge.
  task automatic step(input vec_t v, input int id);
    exp_t e;
    exp_t got;
    @(negedge clk);
    cs        = v.cs;
    we_a      = v.we;
    addr_a    = v.aa;
    data_in_a = v.din;
    addr_b    = v.ab;
    e.ca = v.ca;
    e.ea = v.ea;
    e.cb = v.cb;
    e.eb = v.eb;
    e.id = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.ca) check("data_out_a", got.id, data_out_a, got.ea);
    if (got.cb) check("data_out_b", got.id, data_out_b, got.eb);
  endtask

  initial begin
    vec_t v;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cs        = 1'b0;
    we_a      = 1'b0;
    addr_a    = '0;
    data_in_a = '0;
    addr_b    = '0;

    // Outputs come out of reset at zero.
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", 0, data_out_a, 8'h00);
    check("reset_b", 0, data_out_b, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Preload mem[5] and read it back on both ports.
    add(1, 1,   5, 8'h3C,   5, 0, 0, 0, 0);
    add(1, 0,   5, 8'h00,   5, 1, 8'h3C, 1, 8'h3C);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 100 + i);
    vecs.delete();

    // Mid-cycle async reset clears outputs immediately.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a", 200, data_out_a, 8'h00);
    check("async_rst_b", 200, data_out_b, 8'h00);
    // A write attempted while in reset must be suppressed.
    v = '{cs: 1'b1, we: 1'b1, aa: addr_t'(5), din: 8'h99, ab: addr_t'(5),
          ca: 1'b1, ea: 8'h00, cb: 1'b1, eb: 8'h00};
    step(v, 201);
    @(negedge clk);
    cs   = 1'b0;
    we_a = 1'b0;
    rst  = 1'b0;
    v = '{cs: 1'b1, we: 1'b0, aa: addr_t'(5), din: 8'h00, ab: addr_t'(5),
          ca: 1'b1, ea: 8'h3C, cb: 1'b1, eb: 8'h3C};
    step(v, 202);

    // Burst write, dual read, cs gating, collisions, extremes, back-to-back reads.
    add(1, 1, 100, 8'hAA,   5, 0, 0, 1, 8'h3C);
    add(1, 1, 101, 8'hBB, 100, 0, 0, 1, 8'hAA);
    add(1, 1, 102, 8'hCC, 101, 0, 0, 1, 8'hBB);
    add(1, 1, 103, 8'hDD, 102, 0, 0, 1, 8'hCC);
    add(1, 0, 100, 8'h00, 101, 1, 8'hAA, 1, 8'hBB);
    add(1, 0, 102, 8'h00, 103, 1, 8'hCC, 1, 8'hDD);
    add(0, 1, 100, 8'h55,   5, 1, 8'hCC, 1, 8'hDD);
    add(0, 0,   0, 8'h00, 511, 1, 8'hCC, 1, 8'hDD);
    add(1, 0, 100, 8'h00, 100, 1, 8'hAA, 1, 8'hAA);
    add(1, 1, 200, 8'h11,   5, 0, 0, 1, 8'h3C);
    add(1, 1, 200, 8'h22, 200, 1, 8'h11, 1, 8'h11);
    add(1, 0, 200, 8'h00, 200, 1, 8'h22, 1, 8'h22);
    add(1, 1, 100, 8'h77, 100, 1, 8'hAA, 1, 8'hAA);
    add(1, 0, 100, 8'h00, 100, 1, 8'h77, 1, 8'h77);
    add(1, 1, 100, 8'hAA, 103, 1, 8'h77, 1, 8'hDD);
    add(1, 1,   0, 8'h01, 103, 0, 0, 1, 8'hDD);
    add(1, 1, 511, 8'hFE,   0, 0, 0, 1, 8'h01);
    add(1, 0,   0, 8'h00, 511, 1, 8'h01, 1, 8'hFE);
    add(1, 0,   5, 8'h00, 100, 1, 8'h3C, 1, 8'hAA);
    add(1, 0,   5, 8'h00, 101, 1, 8'h3C, 1, 8'hBB);
    add(1, 0,   5, 8'h00, 102, 1, 8'h3C, 1, 8'hCC);
    add(1, 0,   5, 8'h00, 103, 1, 8'h3C, 1, 8'hDD);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 300 + i);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
